// File: rtl/execute.sv
// ---------------------------------------------------------------------------
// execute -- execute stage of the five-stage RV64 pipeline.
//
// Sits between decode and memory. Single-cycle ALU ops and load/store
// address generation are computed combinationally and registered into
// dataE. RV64M multiply/divide ops run through an iterative FSM
// (radix-2 shift-add multiply, restoring divide) and retire from DONE.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset
//   flushde  in   hold dataE and the mul/div FSM (memory stage stalled)
//   flushall in   squash: kills any in-flight mul/div, invalidates dataE
//   dataD    in   decode bundle (pc, valid, instr, ctl, operands, csr info)
//   dataE    out  registered result bundle for the memory stage
//   stope    out  combinational; high while decode must hold dataD
// ---------------------------------------------------------------------------
package common;
    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        OP_NOP, OP_ALU, OP_LD, OP_SD, OP_MULDIV
    } op_t;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
        ALU_SRA, ALU_OR, ALU_AND, ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW,
        ALU_SRAW, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_MULW,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_DIVW, ALU_DIVUW,
        ALU_REMW, ALU_REMUW
    } alufunc_t;

    typedef struct packed {
        op_t      op;
        alufunc_t alufunc;
    } control_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            valid;
        logic [31:0]     instr;
        control_t        ctl;
        logic [4:0]      dst;
        logic [XLEN-1:0] srca;
        logic [XLEN-1:0] srcb;
        logic [XLEN-1:0] rd2;
        logic [11:0]     csrdst;
        logic [XLEN-1:0] csr;
        logic            error;
    } decode_data_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            valid;
        logic [31:0]     instr;
        control_t        ctl;
        logic [4:0]      dst;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] rd2;
        logic [11:0]     csrdst;
        logic [XLEN-1:0] csr;
        logic            error;
    } excute_data_t;
endpackage

module execute
    import common::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flushde,
    input  logic         flushall,
    input  decode_data_t dataD,
    output excute_data_t dataE,
    output logic         stope
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic is_mul_f(input alufunc_t f);
        return f inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_MULW};
    endfunction

    function automatic logic is_w_f(input alufunc_t f);
        return f inside {ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
    endfunction

    function automatic logic signed_a_f(input alufunc_t f);
        return f inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULW,
                         ALU_DIV, ALU_REM, ALU_DIVW, ALU_REMW};
    endfunction

    function automatic logic signed_b_f(input alufunc_t f);
        return f inside {ALU_MUL, ALU_MULH, ALU_MULW,
                         ALU_DIV, ALU_REM, ALU_DIVW, ALU_REMW};
    endfunction

    state_t       state, state_next;
    logic [6:0]   count;
    excute_data_t held;
    logic [127:0] acc;
    logic [63:0]  mcand, quo, rem, divisor;
    logic         neg_q, neg_r, div_zero;

    logic         is_mop, d_w, d_mul;
    logic [63:0]  opa, opb, mag_a, mag_b;
    logic         neg_a, neg_b;
    logic [63:0]  alu_out, ex_result;
    logic [64:0]  mul_sum, div_trial;
    logic [127:0] acc_next;
    logic [63:0]  quo_next, rem_next;
    alufunc_t     hf;
    logic         h_w;
    logic [127:0] prod, prod_s;
    logic [63:0]  q64, r64, md_result;
    excute_data_t pass_out, done_out;

    assign is_mop = dataD.valid && (dataD.ctl.op == OP_MULDIV);
    assign d_w    = is_w_f(dataD.ctl.alufunc);
    assign d_mul  = is_mul_f(dataD.ctl.alufunc);

    // Operand conditioning for mul/div: W forms look at the low word only,
    // then everything is reduced to a magnitude plus a sign flag.
    always_comb begin
        opa = dataD.srca;
        opb = dataD.srcb;
        if (d_w) begin
            opa = signed_a_f(dataD.ctl.alufunc) ? sext32(dataD.srca[31:0])
                                                : {32'b0, dataD.srca[31:0]};
            opb = signed_b_f(dataD.ctl.alufunc) ? sext32(dataD.srcb[31:0])
                                                : {32'b0, dataD.srcb[31:0]};
        end
        neg_a = signed_a_f(dataD.ctl.alufunc) & opa[63];
        neg_b = signed_b_f(dataD.ctl.alufunc) & opb[63];
        mag_a = neg_a ? (64'd0 - opa) : opa;
        mag_b = neg_b ? (64'd0 - opb) : opb;
    end

    // Single-cycle ALU; loads and stores use the adder for the address.
    always_comb begin
        alu_out = '0;
        case (dataD.ctl.alufunc)
            ALU_ADD:  alu_out = dataD.srca + dataD.srcb;
            ALU_SUB:  alu_out = dataD.srca - dataD.srcb;
            ALU_SLL:  alu_out = dataD.srca << dataD.srcb[5:0];
            ALU_SLT:  alu_out = {63'd0, $signed(dataD.srca) < $signed(dataD.srcb)};
            ALU_SLTU: alu_out = {63'd0, dataD.srca < dataD.srcb};
            ALU_XOR:  alu_out = dataD.srca ^ dataD.srcb;
            ALU_SRL:  alu_out = dataD.srca >> dataD.srcb[5:0];
            ALU_SRA:  alu_out = $unsigned($signed(dataD.srca) >>> dataD.srcb[5:0]);
            ALU_OR:   alu_out = dataD.srca | dataD.srcb;
            ALU_AND:  alu_out = dataD.srca & dataD.srcb;
            ALU_ADDW: alu_out = sext32(dataD.srca[31:0] + dataD.srcb[31:0]);
            ALU_SUBW: alu_out = sext32(dataD.srca[31:0] - dataD.srcb[31:0]);
            ALU_SLLW: alu_out = sext32(dataD.srca[31:0] << dataD.srcb[4:0]);
            ALU_SRLW: alu_out = sext32(dataD.srca[31:0] >> dataD.srcb[4:0]);
            ALU_SRAW: alu_out = sext32($unsigned($signed(dataD.srca[31:0]) >>> dataD.srcb[4:0]));
            default:  alu_out = '0;
        endcase
        if (dataD.ctl.op == OP_LD || dataD.ctl.op == OP_SD)
            ex_result = dataD.srca + dataD.srcb;
        else
            ex_result = alu_out;
    end

    // One iteration step of each engine. The multiplier adds into the top
    // half and shifts the whole accumulator right, consuming a multiplier
    // bit from the bottom. The divider shifts a dividend bit into the
    // partial remainder and keeps the trial subtraction only if it did
    // not go negative.
    always_comb begin
        mul_sum   = {1'b0, acc[127:64]} + (acc[0] ? {1'b0, mcand} : 65'd0);
        acc_next  = {mul_sum, acc[63:1]};
        div_trial = {rem, quo[63]} - {1'b0, divisor};
        if (!div_trial[64]) begin
            rem_next = div_trial[63:0];
            quo_next = {quo[62:0], 1'b1};
        end else begin
            rem_next = {rem[62:0], quo[63]};
            quo_next = {quo[62:0], 1'b0};
        end
    end

    // Final sign fix and result selection. For W ops only 32 iterations
    // run, so the product sits 32 bits up in the accumulator and the
    // quotient ends in the low word.
    always_comb begin
        hf     = held.ctl.alufunc;
        h_w    = is_w_f(hf);
        prod   = h_w ? {32'b0, acc[127:32]} : acc;
        prod_s = neg_q ? (128'd0 - prod) : prod;
        q64    = div_zero ? '1 : (neg_q ? (64'd0 - quo) : quo);
        r64    = div_zero ? held.result : (neg_r ? (64'd0 - rem) : rem);
        case (hf)
            ALU_MUL:                          md_result = prod_s[63:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  md_result = prod_s[127:64];
            ALU_MULW:                         md_result = sext32(prod_s[31:0]);
            ALU_DIV, ALU_DIVU:                md_result = q64;
            ALU_REM, ALU_REMU:                md_result = r64;
            ALU_DIVW, ALU_DIVUW:              md_result = sext32(q64[31:0]);
            ALU_REMW, ALU_REMUW:              md_result = sext32(r64[31:0]);
            default:                          md_result = '0;
        endcase
    end

    always_comb begin
        pass_out        = '0;
        pass_out.pc     = dataD.pc;
        pass_out.valid  = dataD.valid;
        pass_out.instr  = dataD.instr;
        pass_out.ctl    = dataD.ctl;
        pass_out.dst    = dataD.dst;
        pass_out.result = ex_result;
        pass_out.rd2    = dataD.rd2;
        pass_out.csrdst = dataD.csrdst;
        pass_out.csr    = dataD.csr;
        pass_out.error  = dataD.error;
        done_out        = held;
        done_out.valid  = 1'b1;
        done_out.result = md_result;
    end

    assign stope = (state == MUL) || (state == DIV) || ((state == IDLE) && is_mop);

    // Next-state logic. The counter holds the iterations still to run, so
    // the step taken with count == 1 is the last one.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (is_mop) begin
                    if (d_mul)
                        state_next = MUL;
                    else if (opb == 64'd0)
                        state_next = DONE;
                    else
                        state_next = DIV;
                end
            end
            MUL, DIV: begin
                if (count == 7'd1)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // held.result keeps the raw dividend; it is the remainder when the
    // divisor is zero.
    always_ff @(posedge clk) begin
        if (reset || flushall) begin
            state       <= IDLE;
            count       <= '0;
            dataE.valid <= 1'b0;
        end else if (!flushde) begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (is_mop) begin
                        held        <= pass_out;
                        held.result <= dataD.srca;
                        count       <= d_w ? 7'd32 : 7'd64;
                        neg_q       <= neg_a ^ neg_b;
                        neg_r       <= neg_a;
                        div_zero    <= !d_mul && (opb == 64'd0);
                        acc         <= {64'd0, mag_b};
                        mcand       <= mag_a;
                        rem         <= '0;
                        quo         <= d_w ? {mag_a[31:0], 32'd0} : mag_a;
                        divisor     <= mag_b;
                    end
                end
                MUL: begin
                    acc   <= acc_next;
                    count <= count - 7'd1;
                end
                DIV: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count - 7'd1;
                end
                default: ;
            endcase

            if (state == DONE)
                dataE <= done_out;
            else if (stope)
                dataE.valid <= 1'b0;
            else
                dataE <= pass_out;
        end
    end

endmodule

// File: tb/tb_execute.sv
// ---------------------------------------------------------------------------
// tb_execute -- self-checking bench for the execute stage.
//
// Directed cases cover the ALU, load/store, every mul/div flavour and its
// corner cases, stalls, squashes and reset; a randomized run then mixes
// ops with random stall windows. Expected values come from a behavioural
// model using native SystemVerilog arithmetic.
// ---------------------------------------------------------------------------
module tb_execute;
    import common::*;

    logic         clk = 1'b0;
    logic         reset, flushde, flushall;
    decode_data_t dataD;
    excute_data_t dataE;
    logic         stope;

    int checks = 0;
    int passes = 0;

    alufunc_t aluList[15] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                              ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
                              ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW};
    alufunc_t mdList[13]  = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_MULW,
                              ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
                              ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};

    always #5 clk = ~clk;

    execute dut (
        .clk      (clk),
        .reset    (reset),
        .flushde  (flushde),
        .flushall (flushall),
        .dataD    (dataD),
        .dataE    (dataE),
        .stope    (stope)
    );

    // Counts every comparison and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Behavioural reference: RISC-V semantics written with native operators.
    function automatic logic [63:0] refModel(input op_t op, input alufunc_t f,
                                             input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0]  sa, sb, sr;
        logic signed [31:0]  sa32, sb32, sr32;
        logic [31:0]         a32, b32, t32;
        logic signed [127:0] ps;
        logic [127:0]        pu;
        sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
        if (op == OP_LD || op == OP_SD) return a + b;
        case (f)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[5:0];
            ALU_SLT:  return (sa < sb) ? 64'd1 : 64'd0;
            ALU_SLTU: return (a < b) ? 64'd1 : 64'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[5:0];
            ALU_SRA:  begin sr = sa >>> b[5:0]; return sr; end
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_ADDW: begin t32 = a32 + b32; return sx(t32); end
            ALU_SUBW: begin t32 = a32 - b32; return sx(t32); end
            ALU_SLLW: begin t32 = a32 << b[4:0]; return sx(t32); end
            ALU_SRLW: begin t32 = a32 >> b[4:0]; return sx(t32); end
            ALU_SRAW: begin sr32 = sa32 >>> b[4:0]; return sx(sr32); end
            ALU_MUL:  return a * b;
            ALU_MULH: begin
                ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
                return ps[127:64];
            end
            ALU_MULHSU: begin
                ps = $signed({{64{a[63]}}, a}) * $signed({64'd0, b});
                return ps[127:64];
            end
            ALU_MULHU: begin pu = {64'd0, a} * {64'd0, b}; return pu[127:64]; end
            ALU_MULW:  begin t32 = a32 * b32; return sx(t32); end
            ALU_DIV: begin
                if (b == 0) return '1;
                if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
                sr = sa / sb; return sr;
            end
            ALU_DIVU: return (b == 0) ? '1 : a / b;
            ALU_REM: begin
                if (b == 0) return a;
                if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
                sr = sa % sb; return sr;
            end
            ALU_REMU: return (b == 0) ? a : a % b;
            ALU_DIVW: begin
                if (b32 == 0) return '1;
                if (a32 == 32'h8000_0000 && b32 == '1) return sx(a32);
                sr32 = sa32 / sb32; return sx(sr32);
            end
            ALU_DIVUW: begin
                if (b32 == 0) return '1;
                t32 = a32 / b32; return sx(t32);
            end
            ALU_REMW: begin
                if (b32 == 0) return sx(a32);
                if (a32 == 32'h8000_0000 && b32 == '1) return 64'd0;
                sr32 = sa32 % sb32; return sx(sr32);
            end
            ALU_REMUW: begin
                if (b32 == 0) return sx(a32);
                t32 = a32 % b32; return sx(t32);
            end
            default: return 64'd0;
        endcase
    endfunction

    // Cycles from the op appearing in dataD to dataE.valid, with no stalls.
    function automatic int expLatency(input op_t op, input alufunc_t f, input logic [63:0] b);
        bit isW, isDiv;
        if (op != OP_MULDIV) return 1;
        isW   = f inside {ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
        isDiv = f inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
                          ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
        if (isDiv && (isW ? (b[31:0] == 0) : (b == 0))) return 2;
        return isW ? 34 : 66;
    endfunction

    function automatic logic [63:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 20));
            4:       return {$urandom, 32'h8000_0000};
            5:       return {$urandom, 32'hFFFF_FFFF};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Presents one op in dataD (held until dataE.valid), optionally
    // raising flushde for holdLen cycles after holdAt edges, then checks
    // result, passthrough fields, latency and how long stope stayed high.
    task automatic applyStimulus(input op_t op, input alufunc_t f, input logic [63:0] a,
                                 input logic [63:0] b, input string tag,
                                 input int holdAt, input int holdLen);
        logic [63:0] expRes, expPc, expRd2;
        int          base, expLat, expStope, edges, stopeCnt, budget;
        bit          done;
        expPc  = {$urandom, $urandom};
        expRd2 = {$urandom, $urandom};
        dataD.pc          = expPc;
        dataD.valid       = 1'b1;
        dataD.instr       = $urandom;
        dataD.ctl.op      = op;
        dataD.ctl.alufunc = f;
        dataD.dst         = 5'($urandom);
        dataD.srca        = a;
        dataD.srcb        = b;
        dataD.rd2         = expRd2;
        dataD.csrdst      = 12'($urandom);
        dataD.csr         = {$urandom, $urandom};
        dataD.error       = 1'($urandom);

        expRes   = refModel(op, f, a, b);
        base     = expLatency(op, f, b);
        expLat   = base + ((holdAt >= 1 && holdAt < base) ? holdLen : 0);
        expStope = (op == OP_MULDIV) ?
                   (base - 1 + ((holdAt >= 1 && holdAt <= base - 2) ? holdLen : 0)) : 0;

        edges = 0; stopeCnt = 0; done = 0; budget = expLat + 20;
        while (!done && edges < budget) begin
            flushde = (holdAt > 0 && edges >= holdAt && edges < holdAt + holdLen);
            #1;
            if (stope) stopeCnt++;
            @(posedge clk);
            #1;
            edges++;
            if (dataE.valid) done = 1;
        end
        flushde     = 1'b0;
        dataD.valid = 1'b0;

        checkOutput({tag, " result"},  dataE.result, expRes);
        checkOutput({tag, " pc"},      dataE.pc, expPc);
        checkOutput({tag, " rd2"},     dataE.rd2, expRd2);
        checkOutput({tag, " latency"}, 64'(edges), 64'(expLat));
        checkOutput({tag, " stope"},   64'(stopeCnt), 64'(expStope));
    endtask

    // Starts a 64-bit mul/div, aborts it with reset or flushall after
    // atEdge edges, and checks that nothing retires afterwards.
    task automatic abortTest(input string tag, input bit useReset, input alufunc_t f,
                             input int atEdge);
        int seen;
        dataD.valid       = 1'b1;
        dataD.ctl.op      = OP_MULDIV;
        dataD.ctl.alufunc = f;
        dataD.srca        = {$urandom, $urandom};
        dataD.srcb        = {$urandom, $urandom | 32'd1};
        for (int i = 0; i < atEdge; i++) begin
            @(posedge clk);
            #1;
        end
        if (useReset) reset = 1'b1; else flushall = 1'b1;
        if (atEdge > 0) dataD.valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0; flushall = 1'b0; dataD.valid = 1'b0;
        #1;
        checkOutput({tag, " valid"}, {63'd0, dataE.valid}, 64'd0);
        checkOutput({tag, " stope"}, {63'd0, stope}, 64'd0);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (dataE.valid) seen++;
        end
        checkOutput({tag, " no result"}, 64'(seen), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; flushde = 1'b0; flushall = 1'b0; dataD = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset valid", {63'd0, dataE.valid}, 64'd0);
        checkOutput("reset stope", {63'd0, stope}, 64'd0);
        reset = 1'b0;

        applyStimulus(OP_ALU, ALU_ADD, 64'd5, -64'sd7, "add", 0, 0);
        applyStimulus(OP_ALU, ALU_SUBW, 64'h1_0000_0000, 64'd1, "subw", 0, 0);
        applyStimulus(OP_MULDIV, ALU_MULH, -64'sd2, 64'd3, "mulh", 0, 0);
        applyStimulus(OP_MULDIV, ALU_MULHU, 64'h8000_0000_0000_0000, 64'd4, "mulhu", 0, 0);
        applyStimulus(OP_MULDIV, ALU_MULW, 64'h7FFF_FFFF, 64'd2, "mulw", 0, 0);
        applyStimulus(OP_MULDIV, ALU_DIV, -64'sd7, 64'd2, "div", 0, 0);
        applyStimulus(OP_MULDIV, ALU_REM, -64'sd7, 64'd2, "rem", 0, 0);
        applyStimulus(OP_MULDIV, ALU_DIVU, 64'h1234_5678_9ABC_DEF0, 64'd0, "divu0", 0, 0);
        applyStimulus(OP_MULDIV, ALU_DIV, 64'h8000_0000_0000_0000, '1, "divovf", 0, 0);
        applyStimulus(OP_MULDIV, ALU_REMW, 64'h5555_5555_8000_0000, 64'hABCD_0000_0000, "remw0", 0, 0);
        applyStimulus(OP_MULDIV, ALU_DIVW, 64'h8000_0000, 64'hFFFF_FFFF, "divwovf", 0, 0);
        applyStimulus(OP_MULDIV, ALU_DIV, 64'd1_000_003, -64'sd17, "div hold", 10, 5);
        applyStimulus(OP_MULDIV, ALU_MUL, 64'hDEAD_BEEF, 64'h1234_5678, "mul done hold", 65, 3);
        applyStimulus(OP_MULDIV, ALU_MUL, 64'd6, 64'd7, "mul back2back a", 0, 0);
        applyStimulus(OP_MULDIV, ALU_REMU, 64'd100, 64'd7, "remu back2back b", 0, 0);

        abortTest("flushall mid-mul", 1'b0, ALU_MUL, 30);
        applyStimulus(OP_ALU, ALU_ADD, 64'd40, 64'd2, "add after flushall", 0, 0);
        abortTest("flushall at accept", 1'b0, ALU_MULH, 0);
        abortTest("flushall in done", 1'b0, ALU_MUL, 65);
        abortTest("reset mid-div", 1'b1, ALU_DIV, 20);
        applyStimulus(OP_SD, ALU_ADD, 64'h1000, 64'd8, "sd", 0, 0);

        for (int n = 0; n < 60; n++) begin
            op_t      op;
            alufunc_t f;
            int       hAt, hLen;
            case ($urandom_range(0, 3))
                0:       begin op = OP_ALU; f = aluList[$urandom_range(0, 14)]; end
                1:       begin op = ($urandom_range(0, 1) == 0) ? OP_LD : OP_SD;
                               f = aluList[$urandom_range(0, 14)]; end
                default: begin op = OP_MULDIV; f = mdList[$urandom_range(0, 12)]; end
            endcase
            hAt  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 66)) : 0;
            hLen = int'($urandom_range(1, 4));
            applyStimulus(op, f, randOperand(), randOperand(), $sformatf("rand%0d %s", n, f.name()),
                          hAt, hLen);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/execute.md
# execute

Execute stage of the five-stage RV64 pipeline, between decode and memory. It computes single-cycle ALU results and runs an iterative multiply/divide FSM for the RV64M ops. It registers its output as `excute_data_t dataE` for the memory stage. It stalls decode while a mul/div is in flight and holds its output while memory asserts `stopm`.

## Interface
- No parameters; `XLEN` is fixed at 64 by `common`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `flushde` in 1: hold `dataE` and the FSM. Driven by the memory-stage `stopm` / hazard unit.
- `flushall` in 1: squash (trap/redirect). Kills any in-flight mul/div.
- `dataD` in `decode_data_t`: `pc`, `valid`, `instr`, `ctl` (`op`, `alufunc`), `dst`, `srca`, `srcb`, `rd2`, `csrdst`, `csr`, `error`.
- `dataE` out `excute_data_t`: registered result bundle to memory. `result` is the ALU result or the effective address.
- `stope` out 1: combinational. High while the mul/div FSM is not able to accept or retire; upstream must hold `dataD`.

## Operation
- ALU ops (add/sub/sll/slt/sltu/xor/srl/sra/or/and, plus the W forms) finish in one cycle: `result = f(srca, srcb)`.
  - W forms use the low 32 bits and sign-extend bit 31 of the result.
  - Shift amount is `srcb[5:0]`, or `srcb[4:0]` for W forms.
- LD/SD: `result = srca + srcb` (the address). `rd2` passes through unchanged as store data.
- MUL/MULH/MULHSU/MULHU/MULW go through the FSM.
  - Radix-2 shift-add on operand magnitudes, 128-bit accumulator.
  - Sign is fixed in the final cycle.
  - MUL takes the low 64 bits; MULH* take the high 64 bits.
- DIV/DIVU/REM/REMU and the W forms go through the FSM.
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(a) xor sign(b). Remainder sign = sign(a).
- Divide special cases:
  - Divisor zero: quotient = all-ones, remainder = dividend. Resolves in DONE without iterating.
  - Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
  - W forms apply both rules to 32-bit values, then sign-extend.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE to MUL/DIV: valid M-op in `dataD` and not `flushde`. Operands are latched and the counter is loaded with 64 (32 for W forms).
  - MUL/DIV: one iteration per cycle, counter decrements. At 0, go to DONE.
  - DONE to IDLE: when not `flushde`. The result is written into `dataE`.
- `stope` = 1 when the state is MUL or DIV, or when the state is IDLE and `dataD` carries a valid M-op. Otherwise 0.
- `dataE` register update, in priority order:
  - `reset` or `flushall`: `dataE.valid <= 0`; FSM goes to IDLE, counter to 0.
  - Else if `flushde`: hold every field and the FSM state.
  - Else if FSM is in DONE: load the M-op bundle with the computed result, `valid <= 1`.
  - Else if `stope`: `valid <= 0` (bubble).
  - Else: load from `dataD`. `pc`, `instr`, `ctl`, `dst`, `rd2`, `csrdst`, `csr` and `error` copy through; `valid <= dataD.valid`.
- `error` is passed through and never generated here.
- An op with `dataD.valid = 0` never starts the FSM.

## Timing
- Reset values: `dataE.valid = 0`, FSM = IDLE, `stope = 0`. Other `dataE` fields are don't-care.
- ALU and LD/SD latency: 1 cycle (`dataD` in cycle N, `dataE` in N+1).
- Mul/div latency from the op's first cycle in `dataD`:
  - 64-bit: 66 cycles to `dataE.valid` (1 accept + 64 iterate + 1 DONE).
  - W forms: 34 cycles.
  - Divide by zero: 2 cycles.
- `flushde` during MUL/DIV freezes the counter; the latency grows by the number of hold cycles.
- `flushall` in any state (including DONE, and the same cycle as an accept) aborts: the next state is IDLE and no result is produced.
- Back-to-back M-ops: the second is accepted in the cycle after DONE retires.

## Test plan
- ADD with `srca=5`, `srcb=-7` -> next cycle `dataE.result=0xFFFFFFFFFFFFFFFE`, `valid=1`. SUBW with `0x1_0000_0000 - 1` -> `0xFFFFFFFFFFFFFFFF`.
- MULH with `-2 × 3` -> `stope` high for 65 cycles, then `result=0xFFFFFFFFFFFFFFFF`. MULHU with `2^63 × 4` -> `2`. MULW with `0x7FFFFFFF × 2` -> `0xFFFFFFFFFFFFFFFE` after 34 cycles.
- DIV with `-7 / 2` -> `-3`. REM with `-7 / 2` -> `-1`. DIVU by 0 -> `0xFFFF…FFFF` in 2 cycles. DIV of `0x8000…0000 / -1` -> `0x8000…0000`. REMW with `x / 0` (low word `0x80000000`) -> `0xFFFFFFFF80000000`.
- DIV in flight at iteration 10, hold `flushde` for 5 cycles -> result appears 5 cycles later and is correct. Hold `flushde` in DONE -> `dataE` is unchanged until release.
- `flushall` at iteration 30 of a MUL -> `dataE.valid=0` next cycle, FSM in IDLE, `stope=0`. The next ADD completes in 1 cycle.
- `reset` asserted mid-DIV -> `dataE.valid=0` and IDLE next cycle. An SD with `srca=0x1000`, `srcb=8` -> `result=0x1008`, `rd2` preserved.
